conf_int_mul_seq_ctrl: RTL

//  Sequencer for the approximate 16-bit multiplier wrapper in the IDCT datapath.

---
 rtl/conf_int_mul_seq_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/conf_int_mul_seq_ctrl.sv
// Sequencer for the approximate 16-bit multiplier wrapper: steps LOAD/ROW/COL/DRAIN
// over one block, drives the wrapper's state/count0/rstP/rapx, and tracks product validity.
module conf_int_mul_seq_ctrl #(
    parameter int BLK_LEN  = 64,
    parameter int PIPE_LAT = 3
) (
    input  logic       clk,
    input  logic       racc,
    input  logic       start,
    input  logic       apx_en,
    input  logic       in_valid,
    output logic       busy,
    output logic [2:0] mul_state,
    output logic [8:0] count0,
    output logic       rstP,
    output logic       rapx,
    output logic       p_valid,
    output logic       done
);

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_LOAD  = 3'b001;
    localparam logic [2:0] S_ROW   = 3'b010;
    localparam logic [2:0] S_COL   = 3'b011;
    localparam logic [2:0] S_DRAIN = 3'b100;

    localparam logic [8:0] CNT_LAST = 9'(BLK_LEN - 1);
    localparam int         DW       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

    logic [2:0]          r_state;
    logic [8:0]          r_cnt;
    logic [DW-1:0]       r_drain;
    logic                r_busy;
    logic                r_rstp;
    logic                r_rapx;
    logic [PIPE_LAT-1:0] r_vld_pipe;

    logic [2:0]    w_state_nxt;
    logic [8:0]    w_cnt_nxt;
    logic [DW-1:0] w_drain_nxt;
    logic          w_busy_nxt;
    logic          w_rstp_nxt;
    logic          w_rapx_nxt;
    logic          w_phase_last;
    logic          w_opnd;
    logic          w_drain_end;

    assign w_phase_last = in_valid && (r_cnt == CNT_LAST);
    assign w_opnd       = in_valid && ((r_state == S_ROW) || (r_state == S_COL));
    assign w_drain_end  = (r_state == S_DRAIN) && (r_drain == DRAIN_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_drain_nxt = r_drain;
        w_busy_nxt  = r_busy;
        w_rstp_nxt  = 1'b0;
        w_rapx_nxt  = r_rapx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_busy_nxt  = 1'b1;
                    w_rapx_nxt  = apx_en;
                    w_cnt_nxt   = 9'd0;
                end
            end
            S_LOAD, S_ROW, S_COL: begin
                if (w_phase_last) begin
                    w_cnt_nxt = 9'd0;
                    case (r_state)
                        S_LOAD: begin
                            w_state_nxt = S_ROW;
                            w_rstp_nxt  = 1'b1;
                        end
                        S_ROW: begin
                            w_state_nxt = S_COL;
                            w_rstp_nxt  = 1'b1;
                        end
                        default: begin
                            w_state_nxt = S_DRAIN;
                            w_drain_nxt = '0;
                        end
                    endcase
                end else if (in_valid) begin
                    w_cnt_nxt = r_cnt + 9'd1;
                end
            end
            S_DRAIN: begin
                // in_valid is ignored here; only the pipeline tail is being flushed
                if (w_drain_end) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_drain_nxt = r_drain + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = 9'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge racc) begin
        if (racc) begin
            r_state <= S_IDLE;
            r_cnt   <= 9'd0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_rstp  <= 1'b1;
            r_rapx  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drain <= w_drain_nxt;
            r_busy  <= w_busy_nxt;
            r_rstp  <= w_rstp_nxt;
            r_rapx  <= w_rapx_nxt;
        end
    end

    // Product-valid shift register mirrors the wrapper's multiply latency; bubbles ride along.
    always_ff @(posedge clk or posedge racc) begin
        if (racc) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[PIPE_LAT-2:0], w_opnd};
        end
    end

    assign busy      = r_busy;
    assign mul_state = r_state;
    assign count0    = r_cnt;
    assign rstP      = r_rstp;
    assign rapx      = r_rapx;
    assign p_valid   = r_vld_pipe[PIPE_LAT-1];
    assign done      = w_drain_end;

endmodule
